// File: rtl/mtr_drv_gen.sv
// mtr_drv_gen: N-phase BLDC bridge driver. One shared PWM feeds per-phase mode decode and
// dead-time FSMs; an over-current latch overrides every gate until explicitly cleared.

module mtr_drv_gen #(
  parameter int PWM_W    = 11,
  parameter int N_PH     = 3,
  parameter int DEADTIME = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PWM_W-1:0]  duty,
  input  logic [2*N_PH-1:0] sel,
  input  logic              ocp,
  input  logic              fault_clr,
  output logic [N_PH-1:0]   high,
  output logic [N_PH-1:0]   low,
  output logic              PWM_synch,
  output logic              fault
);
  typedef enum logic [1:0] {COAST = 2'b00, REV = 2'b01, FWD = 2'b10, BRAKE = 2'b11} phMode_e;
  typedef struct packed { logic hi; logic lo; } gateReq_t;

  localparam logic [PWM_W-1:0] CNT_LAST = '1;

  logic [PWM_W-1:0] cnt, dutyQ;
  logic             pwmSig;
  logic             ocpMeta, ocpS;
  logic             kill;

  // duty is only sampled on the last count so a period is never split between two duties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      dutyQ     <= '0;
      pwmSig    <= 1'b0;
      PWM_synch <= 1'b0;
    end else begin
      cnt       <= cnt + 1'b1;
      pwmSig    <= (cnt < dutyQ);
      PWM_synch <= (cnt == CNT_LAST);
      if (cnt == CNT_LAST) dutyQ <= duty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ocpMeta <= 1'b0;
      ocpS    <= 1'b0;
      fault   <= 1'b0;
    end else begin
      ocpMeta <= ocp;
      ocpS    <= ocpMeta;
      if (ocpS)           fault <= 1'b1;
      else if (fault_clr) fault <= 1'b0;
    end
  end

  // ocpS kills the gates in the same edge that sets fault, saving a cycle of shoot-through exposure
  assign kill = ocpS | fault;

  genvar p;
  generate
    for (p = 0; p < N_PH; p++) begin : g_ph
      phMode_e  mode;
      gateReq_t req;

      assign mode = phMode_e'(sel[2*p +: 2]);

      always_comb begin
        req = '0;
        case (mode)
          COAST:   req = '0;
          REV:     req = {~pwmSig, pwmSig};
          FWD:     req = {pwmSig, ~pwmSig};
          BRAKE:   req = {1'b0, 1'b1};
          default: req = '0;
        endcase
      end

      mtr_drv_phase #(.DEADTIME(DEADTIME)) u_ph (
        .clk   (clk),
        .rst_n (rst_n),
        .hiReq (req.hi),
        .loReq (req.lo),
        .kill  (kill),
        .high  (high[p]),
        .low   (low[p])
      );
    end
  endgenerate

endmodule

// mtr_drv_phase: one bridge leg. Any request change opens a DEADTIME gap with both gates low;
// kill parks the leg in DEAD with a fresh count so recovery always waits a full gap.
module mtr_drv_phase #(
  parameter int DEADTIME = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hiReq,
  input  logic loReq,
  input  logic kill,
  output logic high,
  output logic low
);
  localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEADTIME - 1);

  typedef enum logic {RUN = 1'b0, DEAD = 1'b1} phState_e;

  phState_e      state;
  logic [DW-1:0] dcnt;
  logic          hiPrev, loPrev;
  logic          reqChg;

  assign reqChg = (hiReq != hiPrev) || (loReq != loPrev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= DEAD;
      dcnt   <= '0;
      hiPrev <= 1'b0;
      loPrev <= 1'b0;
      high   <= 1'b0;
      low    <= 1'b0;
    end else begin
      hiPrev <= hiReq;
      loPrev <= loReq;
      if (kill) begin
        state <= DEAD;
        dcnt  <= '0;
        high  <= 1'b0;
        low   <= 1'b0;
      end else begin
        case (state)
          RUN: begin
            if (reqChg) begin
              state <= DEAD;
              dcnt  <= '0;
              high  <= 1'b0;
              low   <= 1'b0;
            end else begin
              high <= hiReq;
              low  <= loReq;
            end
          end
          DEAD: begin
            high <= 1'b0;
            low  <= 1'b0;
            if (reqChg) begin
              dcnt <= '0;
            end else begin
              dcnt <= dcnt + 1'b1;
              if (dcnt == DCNT_LAST) state <= RUN;
            end
          end
          default: begin
            state <= DEAD;
            dcnt  <= '0;
            high  <= 1'b0;
            low   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mtr_drv_gen.sv
// Directed bench for mtr_drv_gen: default 3-phase instance plus a small 4-phase instance.
module tb_mtr_drv_gen;
  localparam int PW_A = 11, NP_A = 3, DT_A = 32, PER_A = 2048;
  localparam int PW_B = 8,  NP_B = 4, DT_B = 4,  PER_B = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstA, ocpA, clrA, synA, faultA;
  logic [PW_A-1:0]   dutyA;
  logic [2*NP_A-1:0] selA;
  logic [NP_A-1:0]   highA, lowA;

  logic              rstB, ocpB, clrB, synB, faultB;
  logic [PW_B-1:0]   dutyB;
  logic [2*NP_B-1:0] selB;
  logic [NP_B-1:0]   highB, lowB;

  mtr_drv_gen #(.PWM_W(PW_A), .N_PH(NP_A), .DEADTIME(DT_A)) dutA (
    .clk(clk), .rst_n(rstA), .duty(dutyA), .sel(selA), .ocp(ocpA), .fault_clr(clrA),
    .high(highA), .low(lowA), .PWM_synch(synA), .fault(faultA)
  );

  mtr_drv_gen #(.PWM_W(PW_B), .N_PH(NP_B), .DEADTIME(DT_B)) dutB (
    .clk(clk), .rst_n(rstB), .duty(dutyB), .sel(selB), .ocp(ocpB), .fault_clr(clrB),
    .high(highB), .low(lowB), .PWM_synch(synB), .fault(faultB)
  );

  int nChk = 0, nBad = 0;
  int shootA = 0, shootB = 0;

  always @(negedge clk) begin
    if ((highA & lowA) != '0) shootA++;
    if ((highB & lowB) != '0) shootB++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChk++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic waitSynch(input bit useB, output int n);
    n = -1;
    for (int i = 1; i <= 5000; i++) begin
      @(posedge clk); #1;
      if ((useB ? synB : synA) == 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Edges until the chosen gate of phase p rises; other flags any sight of the opposite gate.
  task automatic waitGate(input bit useB, input bit isLow, input int p, output int n, output bit other);
    logic [7:0] hv, lv;
    n = -1;
    other = 1'b0;
    for (int i = 1; i <= 3000; i++) begin
      @(posedge clk); #1;
      hv = useB ? 8'(highB) : 8'(highA);
      lv = useB ? 8'(lowB)  : 8'(lowA);
      if (isLow ? hv[p[2:0]] : lv[p[2:0]]) other = 1'b1;
      if (isLow ? lv[p[2:0]] : hv[p[2:0]]) begin
        n = i;
        break;
      end
    end
  endtask

  // One PWM period of samples: phase-0 on counts, longest phase-0 both-low run, any-gate and synch counts.
  task automatic measureWin(input bit useB, input int changeAt, input logic [PW_A-1:0] newDuty,
                            output int hiC, output int loC, output int gapMax, output int anyC,
                            output int syC);
    logic [7:0] hv, lv;
    int len, cur;
    len = useB ? PER_B : PER_A;
    hiC = 0; loC = 0; gapMax = 0; anyC = 0; syC = 0; cur = 0;
    for (int i = 0; i < len; i++) begin
      if (i == changeAt) dutyA = newDuty;
      @(posedge clk); #1;
      hv = useB ? 8'(highB) : 8'(highA);
      lv = useB ? 8'(lowB)  : 8'(lowA);
      if (hv[0]) hiC++;
      if (lv[0]) loC++;
      if ((hv | lv) != '0) anyC++;
      if (!hv[0] && !lv[0]) begin
        cur++;
        if (cur > gapMax) gapMax = cur;
      end else begin
        cur = 0;
      end
      if (useB ? synB : synA) syC++;
    end
  endtask

  initial begin
    int  n, hc, lc, gm, ac, sc;
    bit  oth;

    rstA = 1'b0; ocpA = 1'b0; clrA = 1'b0; dutyA = 11'd1024; selA = '0;
    rstB = 1'b0; ocpB = 1'b0; clrB = 1'b0; dutyB = 8'd128;   selB = 8'b0000_0010;

    repeat (3) @(posedge clk); #1;
    chk("rstHighA",  32'(highA),  0);
    chk("rstLowA",   32'(lowA),   0);
    chk("rstSynchA", 32'(synA),   0);
    chk("rstFaultA", 32'(faultA), 0);
    chk("rstLowB",   32'(lowB),   0);

    // coast: no gates, synch every period, first pulse one full period after release
    rstA = 1'b1;
    waitSynch(1'b0, n);
    chk("firstSynch", n, PER_A);
    measureWin(1'b0, -1, '0, hc, lc, gm, ac, sc);
    chk("coastAnyGate", ac, 0);
    chk("coastSynch",   sc, 1);

    // forward on phase 0, duty 1024
    selA = 6'b00_00_10;
    waitSynch(1'b0, n);
    chk("synchPeriod", n, PER_A);
    measureWin(1'b0, -1, '0, hc, lc, gm, ac, sc);
    chk("fwdHighOn", hc, 1024 - DT_A - 1);
    chk("fwdLowOn",  lc, 1024 - DT_A - 1);
    chk("fwdGap",    gm, DT_A + 1);
    chk("fwdSynch",  sc, 1);

    // duty change mid-period waits for the period boundary
    measureWin(1'b0, 500, 11'd256, hc, lc, gm, ac, sc);
    chk("dutyHoldHigh", hc, 1024 - DT_A - 1);
    chk("dutyHoldLow",  lc, 1024 - DT_A - 1);
    measureWin(1'b0, 500, 11'd0, hc, lc, gm, ac, sc);
    chk("duty256High", hc, 256 - DT_A - 1);
    chk("duty256Low",  lc, PER_A - 256 - DT_A - 1);
    measureWin(1'b0, -1, '0, hc, lc, gm, ac, sc);
    chk("duty0High", hc, 0);
    chk("duty0Low",  lc, PER_A);

    // phase 1: reverse (high on, duty 0) then brake, then a restart at dcnt=20
    selA = 6'b00_01_10;
    repeat (50) @(posedge clk); #1;
    chk("revHigh1", 32'(highA[1]), 1);
    chk("revLow1",  32'(lowA[1]),  0);
    selA = 6'b00_11_10;
    waitGate(1'b0, 1'b1, 1, n, oth);
    chk("brakeDelay",  n,   DT_A + 2);
    chk("brakeNoHigh", oth, 0);
    selA = 6'b00_01_10;
    repeat (21) @(posedge clk); #1;
    chk("restartGatesOff", 32'({highA[1], lowA[1]}), 0);
    selA = 6'b00_11_10;
    waitGate(1'b0, 1'b1, 1, n, oth);
    chk("restartDelay",  n,   DT_A + 2);
    chk("restartNoHigh", oth, 0);

    // over-current: one-cycle pulse, synchroniser latency, latched fault, gated clear
    ocpA = 1'b1;
    @(posedge clk); #1; ocpA = 1'b0;
    @(posedge clk); #1;
    chk("ocpNotYet", 32'(lowA), 3'b011);
    @(posedge clk); #1;
    chk("ocpKillLow",  32'(lowA),   0);
    chk("ocpKillHigh", 32'(highA),  0);
    chk("ocpFault",    32'(faultA), 1);
    ocpA = 1'b1;
    repeat (4) @(posedge clk); #1;
    clrA = 1'b1;
    @(posedge clk); #1; clrA = 1'b0;
    chk("clrIgnored", 32'(faultA), 1);
    ocpA = 1'b0;
    repeat (5) @(posedge clk); #1;
    chk("faultLatched", 32'(faultA), 1);
    chk("faultGates",   32'(lowA),   0);
    clrA = 1'b1;
    @(posedge clk); #1; clrA = 1'b0;
    chk("faultCleared", 32'(faultA), 0);
    waitGate(1'b0, 1'b1, 0, n, oth);
    chk("clrDelay",  n,   DT_A + 1);
    chk("clrNoHigh", oth, 0);
    chk("clrResume", 32'(lowA), 3'b011);

    // reset mid-RUN
    @(posedge clk); #3; rstA = 1'b0; #1;
    chk("rstRunLow",  32'(lowA),  0);
    chk("rstRunHigh", 32'(highA), 0);
    repeat (3) @(posedge clk); #1; rstA = 1'b1;
    waitGate(1'b0, 1'b1, 0, n, oth);
    chk("rstRunDelay", n, DT_A + 2);
    chk("rstRunAll",   32'(lowA), 3'b011);

    // reset mid-DEAD (phase 0 switching to reverse)
    selA = 6'b00_11_01;
    repeat (10) @(posedge clk); #1;
    chk("deadGatesOff", 32'({highA[0], lowA[0]}), 0);
    #2; rstA = 1'b0; #1;
    chk("rstDeadLow", 32'(lowA), 0);
    repeat (2) @(posedge clk); #1; rstA = 1'b1;
    waitGate(1'b0, 1'b0, 0, n, oth);
    chk("rstDeadDelay", n,   DT_A + 2);
    chk("rstDeadNoLow", oth, 0);
    chk("shootThroughA", shootA, 0);

    // small instance: 4 phases, period 256, dead-time 4
    rstB = 1'b1;
    waitSynch(1'b1, n);
    chk("bFirstSynch", n, PER_B);
    measureWin(1'b1, -1, '0, hc, lc, gm, ac, sc);
    chk("bHighOn", hc, 128 - DT_B - 1);
    chk("bLowOn",  lc, PER_B - 128 - DT_B - 1);
    chk("bGap",    gm, DT_B + 1);
    chk("bSynch",  sc, 1);
    @(posedge clk); #3; rstB = 1'b0; #1;
    chk("bRstGates", 32'({highB, lowB}), 0);
    repeat (2) @(posedge clk); #1; rstB = 1'b1;
    waitGate(1'b1, 1'b1, 0, n, oth);
    chk("bRstDelay", n, DT_B + 2);
    chk("shootThroughB", shootB, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChk, nBad);
    $finish;
  end

endmodule
